// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide unit: funct codes, FSM states and sizing.
package muldiv_ctrl_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int MD_ITERS   = DATA_WIDTH;

   typedef enum logic [5:0] {
      F_MTHI  = 6'h11,
      F_MTLO  = 6'h13,
      F_MULT  = 6'h18,
      F_MULTU = 6'h19,
      F_DIV   = 6'h1a,
      F_DIVU  = 6'h1b
   } funct_type;

   typedef enum logic [2:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_FIX,
      MD_DONE
   } muldiv_state_type;

   typedef logic [2*DATA_WIDTH-1:0] dword_type;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             div_mode,
   input  logic [WIDTH:0]   hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH:0]   hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum     = hi + {1'b0, opb};
      shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, opb};
      hi_next = hi;
      lo_next = lo;
      if (div_mode) begin
         // A clear sign bit means the trial subtraction fits: keep it and shift in a 1.
         if (!diff[WIDTH+1]) begin
            hi_next = diff[WIDTH:0];
            lo_next = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_next = shifted;
            lo_next = {lo[WIDTH-2:0], 1'b0};
         end
      end else if (lo[0]) begin
         hi_next = {1'b0, sum[WIDTH:1]};
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end else begin
         hi_next = {1'b0, hi[WIDTH:1]};
         lo_next = {hi[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU over WIDTH iterations and handles MTHI/MTLO.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [5:0]       funct_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   muldiv_state_type   state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH-1:0]   rs_hold;
   logic               op_mul, neg_res, neg_a, dbz;

   logic [WIDTH:0]     acc_next;
   logic [WIDTH-1:0]   work_next;
   logic [2*WIDTH-1:0] prod_raw, prod;
   logic [WIDTH-1:0]   quo, rem, a_mag, b_mag;
   logic               is_mul_req, is_div_req, is_signed_req;

   // Most negative value maps to itself, which is its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_mode (state == MD_DIV),
      .hi       (acc),
      .lo       (work),
      .opb      (opb),
      .hi_next  (acc_next),
      .lo_next  (work_next)
   );

   always_comb begin
      is_mul_req    = (funct_i == F_MULT) || (funct_i == F_MULTU);
      is_div_req    = (funct_i == F_DIV)  || (funct_i == F_DIVU);
      is_signed_req = (funct_i == F_MULT) || (funct_i == F_DIV);
      a_mag         = mag(rs_i, is_signed_req);
      b_mag         = mag(rt_i, is_signed_req);
      prod_raw      = {acc[WIDTH-1:0], work};
      prod          = neg_res ? -prod_raw : prod_raw;
      quo           = neg_res ? -work : work;
      rem           = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= MD_IDLE;
         cnt           <= '0;
         acc           <= '0;
         work          <= '0;
         opb           <= '0;
         rs_hold       <= '0;
         op_mul        <= 1'b0;
         neg_res       <= 1'b0;
         neg_a         <= 1'b0;
         dbz           <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
         hi_o          <= '0;
         lo_o          <= '0;
      end else begin
         done_o        <= 1'b0;
         div_by_zero_o <= 1'b0;
         case (state)
            MD_IDLE, MD_DONE: begin
               state <= MD_IDLE;
               if (start_i) begin
                  if (is_mul_req || is_div_req) begin
                     rs_hold <= rs_i;
                     neg_res <= is_signed_req & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                     neg_a   <= is_signed_req & rs_i[WIDTH-1];
                     dbz     <= is_div_req && (rt_i == '0);
                     op_mul  <= is_mul_req;
                     cnt     <= '0;
                     acc     <= '0;
                     busy_o  <= 1'b1;
                     if (is_mul_req) begin
                        opb   <= a_mag;
                        work  <= b_mag;
                        state <= MD_MUL;
                     end else begin
                        opb   <= b_mag;
                        work  <= a_mag;
                        state <= MD_DIV;
                     end
                  end else if (funct_i == F_MTHI) begin
                     hi_o   <= rs_i;
                     done_o <= 1'b1;
                     state  <= MD_DONE;
                  end else if (funct_i == F_MTLO) begin
                     lo_o   <= rs_i;
                     done_o <= 1'b1;
                     state  <= MD_DONE;
                  end
               end
            end
            MD_MUL, MD_DIV: begin
               acc  <= acc_next;
               work <= work_next;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= MD_FIX;
               end
            end
            MD_FIX: begin
               busy_o <= 1'b0;
               done_o <= 1'b1;
               state  <= MD_DONE;
               if (op_mul) begin
                  hi_o <= prod[2*WIDTH-1:WIDTH];
                  lo_o <= prod[WIDTH-1:0];
               end else if (dbz) begin
                  hi_o          <= rs_hold;
                  lo_o          <= '1;
                  div_by_zero_o <= 1'b1;
               end else begin
                  hi_o <= rem;
                  lo_o <= quo;
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int W = DATA_WIDTH;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [5:0]   funct = '0;
   logic [W-1:0] rs = '0;
   logic [W-1:0] rt = '0;
   logic         busy, done, dbz;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .funct_i       (funct),
      .rs_i          (rs),
      .rt_i          (rt),
      .busy_o        (busy),
      .done_o        (done),
      .div_by_zero_o (dbz),
      .hi_o          (hi),
      .lo_o          (lo)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of one multiply/divide, from plain 64-bit arithmetic.
   function automatic void compute(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      dword_type       p;
      h = '0;
      l = '0;
      z = 1'b0;
      case (f)
         F_MULT:  begin p = dword_type'(sa * sb); h = p[2*W-1:W]; l = p[W-1:0]; end
         F_MULTU: begin p = dword_type'(ua * ub); h = p[2*W-1:W]; l = p[W-1:0]; end
         F_DIV, F_DIVU: begin
            if (b == '0) begin
               h = a; l = '1; z = 1'b1;
            end else if (f == F_DIV) begin
               l = W'(sa / sb); h = W'(sa % sb);
            end else begin
               l = W'(ua / ub); h = W'(ua % ub);
            end
         end
         default: ;
      endcase
   endfunction

   // Model: a countdown of remaining busy cycles instead of an FSM.
   logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic [W-1:0] p_hi = '0, p_lo = '0;
   logic         p_dbz = 1'b0;
   int           remain = 0;

   always @(posedge clk) begin : model
      int           r;
      logic [W-1:0] nh, nl, ph, pl;
      logic         nd, nz, pz;
      r  = remain;
      nh = m_hi;  nl = m_lo;
      ph = p_hi;  pl = p_lo;  pz = p_dbz;
      nd = 1'b0;  nz = 1'b0;
      if (!rst_n) begin
         r = 0; nh = '0; nl = '0;
      end else if (r > 0) begin
         r = r - 1;
         if (r == 0) begin
            nh = ph; nl = pl; nd = 1'b1; nz = pz;
         end
      end else if (start) begin
         case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
               compute(funct, rs, rt, ph, pl, pz);
               r = MD_ITERS + 1;
            end
            F_MTHI: begin nh = rs; nd = 1'b1; end
            F_MTLO: begin nl = rs; nd = 1'b1; end
            default: ;
         endcase
      end
      remain <= r;
      m_busy <= (r > 0);
      m_done <= nd;
      m_dbz  <= nz;
      m_hi   <= nh;
      m_lo   <= nl;
      p_hi   <= ph;
      p_lo   <= pl;
      p_dbz  <= pz;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_busy", busy, m_busy);
         check("cyc_done", done, m_done);
         check("cyc_dbz",  dbz,  m_dbz);
         check("cyc_hi",   hi,   m_hi);
         check("cyc_lo",   lo,   m_lo);
      end
   end

   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; funct = f; rs = a; rt = b;
      @(posedge clk); #1;
      start = 1'b0; rs = ~a; rt = ~b;
   endtask

   task automatic wait_done(input int already, output int n);
      n = already;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ez);
      int n;
      issue(f, a, b);
      wait_done(0, n);
      check({name, "_latency"}, 64'(n), 64'(MD_ITERS + 1));
      check({name, "_hi"}, hi, eh);
      check({name, "_lo"}, lo, el);
      check({name, "_dbz"}, dbz, ez);
   endtask

   task automatic count_done(input string name, input int cycles);
      int extra = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done) extra++;
      end
      check(name, 64'(extra), 64'd0);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      @(posedge clk); #1;

      run_op("mult_neg",   F_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("multu_big",  F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
      run_op("div_neg7",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_ovf",    F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run_op("div_negdiv", F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_zero",  F_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
      check("divu_zero_done", done, 1'b1);
      run_op("div_zero",   F_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
      run_op("divu_big",   F_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

      // Second request while busy must vanish.
      issue(F_MULTU, 32'd3, 32'd5);
      repeat (4) begin @(posedge clk); #1; end
      start = 1'b1; funct = F_DIVU; rs = 32'd100; rt = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, n);
      check("busy_ign_latency", 64'(n), 64'(MD_ITERS + 1));
      check("busy_ign_hi", hi, 32'd0);
      check("busy_ign_lo", lo, 32'd15);
      count_done("busy_ign_extra_done", 40);

      issue(6'h20, 32'h55, 32'h66);
      check("bad_funct_busy", busy, 1'b0);
      check("bad_funct_done", done, 1'b0);

      issue(F_MTHI, 32'h0000_1234, 32'h0);
      check("mthi_hi", hi, 32'h0000_1234);
      check("mthi_done", done, 1'b1);
      check("mthi_busy", busy, 1'b0);
      @(posedge clk); #1;
      check("mthi_done_once", done, 1'b0);
      issue(F_MTLO, 32'h0000_5678, 32'h0);
      check("mtlo_lo", lo, 32'h0000_5678);
      check("mtlo_hi_kept", hi, 32'h0000_1234);

      // Reset in the middle of a multiply.
      issue(F_MULT, 32'h0000_1234, 32'h0000_0010);
      repeat (9) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi, '0);
      check("abort_lo", lo, '0);
      count_done("abort_no_done", 40);

      run_op("post_rst_mult", F_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 1'b0);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
